// File: rtl/alu_operand_sequencer.sv
// Feeds (op, A, B) nibbles to an external 4-bit ALU and returns the registered result over valid/ready.
// Optional result chaining (reuse previous result as A) is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_operand_sequencer #(
    parameter int DW    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic [1:0]       alu_op,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic [DW-1:0]    alu_ans,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       out_op,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [2:0] {S_OP, S_A, S_B, S_EXEC, S_OUT} stateT;

    stateT state;
    stateT nextState;
    logic  accept;
    logic  chainHit;

    assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_CHAIN_EN
    // Set once any result has been consumed, so a chained op has a valid previous result to use.
    logic havePrev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            havePrev <= 1'b0;
        end else if (state == S_OUT && out_ready) begin
            havePrev <= 1'b1;
        end
    end

    assign chainHit = havePrev && in_data[3];
`else
    assign chainHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OP;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_OP);
        case (state)
            S_OP: begin
                in_ready = rst_n;
                if (accept) nextState = chainHit ? S_B : S_A;
            end
            S_A: begin
                in_ready = rst_n;
                if (accept) nextState = S_B;
            end
            S_B: begin
                in_ready = rst_n;
                if (accept) nextState = S_EXEC;
            end
            S_EXEC: begin
                nextState = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) nextState = S_OP;
            end
            default: begin
                nextState = S_OP;
            end
        endcase
    end

    // Operand registers hold until overwritten; the ALU result is sampled only in S_EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            out_data <= '0;
            out_op   <= '0;
            txn_cnt  <= '0;
        end else begin
            case (state)
                S_OP: begin
                    if (accept) begin
                        alu_op <= in_data[1:0];
                        if (chainHit) alu_a <= out_data;
                    end
                end
                S_A: begin
                    if (accept) alu_a <= in_data;
                end
                S_B: begin
                    if (accept) alu_b <= in_data;
                end
                S_EXEC: begin
                    out_data <= alu_ans;
                    out_op   <= alu_op;
                end
                S_OUT: begin
                    if (out_ready) txn_cnt <= txn_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural ALU and a result scoreboard.
// Define ALU_SEQ_CHAIN_EN for both bench and RTL to exercise result chaining.
module tb_alu_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_ans;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_op;
    logic       busy;
    logic [7:0] txn_cnt;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] data;
    } resultT;

    resultT     expQ[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] expCnt     = '0;

    alu_operand_sequencer #(.DW(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ans   (alu_ans),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .busy      (busy),
        .txn_cnt   (txn_cnt)
    );

    function automatic logic [3:0] aluRef(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Stand-in for the external combinational ALU.
    always_comb alu_ans = aluRef(alu_op, alu_a, alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle gap cycles carry random data with in_valid low and must not disturb anything.
    task automatic applyStimulus(input logic [3:0] v, input int gaps);
        logic [1:0] holdOp;
        logic [3:0] holdA;
        logic [3:0] holdB;
        logic       holdBusy;
        int         waitCnt;
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom_range(0, 15));
            holdOp   = alu_op;
            holdA    = alu_a;
            holdB    = alu_b;
            holdBusy = busy;
            tick();
            checkOutput("gapOp", alu_op, holdOp);
            checkOutput("gapA", alu_a, holdA);
            checkOutput("gapB", alu_b, holdB);
            checkOutput("gapState", busy, holdBusy);
        end
        in_valid = 1'b1;
        in_data  = v;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkOutput("inReadyWait", waitCnt < 50, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic sendTxn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] expData, input int gaps);
        applyStimulus(op, gaps);
        applyStimulus(a, gaps);
        applyStimulus(b, gaps);
        expQ.push_back({op[1:0], expData});
    endtask

    task automatic collectOutput(input int stall);
        int         waitCnt;
        resultT     e;
        logic [3:0] held;
        waitCnt   = 0;
        out_ready = 1'b0;
        while (!out_valid && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput("outValidWait", waitCnt < 20, 1);
        checkOutput("scoreboardDepth", expQ.size() > 0, 1);
        e    = (expQ.size() > 0) ? expQ.pop_front() : '0;
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("stallValid", out_valid, 1);
            checkOutput("stallData", out_data, held);
            checkOutput("stallInReady", in_ready, 0);
            checkOutput("stallCnt", txn_cnt, expCnt);
        end
        checkOutput("outData", out_data, e.data);
        checkOutput("outOp", out_op, e.op);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        expCnt++;
        checkOutput("txnCnt", txn_cnt, expCnt);
        checkOutput("backToOp", busy, 0);
        if (stall > 0) begin
            tick();
            checkOutput("txnCntOnce", txn_cnt, expCnt);
        end
    endtask

    initial begin
        logic       wrapped;
        logic [3:0] rOp;
        logic [3:0] rA;
        logic [3:0] rB;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        checkOutput("rstInReady", in_ready, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstAluOp", alu_op, 0);
        checkOutput("rstAluA", alu_a, 0);
        checkOutput("rstAluB", alu_b, 0);
        checkOutput("rstOutData", out_data, 0);
        checkOutput("rstOutOp", out_op, 0);
        checkOutput("rstTxnCnt", txn_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("postRstInReady", in_ready, 1);

        $display("[TB] AND 0xC & 0xA with latency check");
        applyStimulus(4'h0, 0);
        applyStimulus(4'hC, 0);
        applyStimulus(4'hA, 0);
        expQ.push_back({2'b00, 4'h8});
        checkOutput("operandA", alu_a, 4'hC);
        checkOutput("operandB", alu_b, 4'hA);
        checkOutput("latencyEarly", out_valid, 0);
        tick();
        checkOutput("latencyValid", out_valid, 1);
        collectOutput(0);

        $display("[TB] ADD 9 + 8 drops carry");
        sendTxn(4'h3, 4'h9, 4'h8, 4'h1, 0);
        collectOutput(0);

        $display("[TB] backpressure for 5 cycles");
        sendTxn(4'h2, 4'hF, 4'h3, 4'hC, 0);
        collectOutput(5);

        $display("[TB] XOR with in_valid gaps");
        sendTxn(4'h2, 4'h6, 4'h3, 4'h5, 1 + int'($urandom_range(0, 2)));
        collectOutput(0);

        $display("[TB] reset mid-transaction");
        applyStimulus(4'h3, 0);
        applyStimulus(4'h7, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstInReady", in_ready, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstAluOp", alu_op, 0);
        checkOutput("midRstAluA", alu_a, 0);
        checkOutput("midRstOutData", out_data, 0);
        checkOutput("midRstTxnCnt", txn_cnt, 0);
        tick();
        rst_n  = 1'b1;
        expCnt = '0;
        #1;
        checkOutput("midRstReleaseReady", in_ready, 1);
        sendTxn(4'h1, 4'h3, 4'h4, 4'h7, 0);
        collectOutput(0);

`ifdef ALU_SEQ_CHAIN_EN
        $display("[TB] chained XOR with previous result");
        applyStimulus(4'hA, 0);
        checkOutput("chainA", alu_a, 4'h7);
        applyStimulus(4'h5, 0);
        expQ.push_back({2'b10, 4'h2});
        collectOutput(0);
`else
        $display("[TB] chain flag ignored");
        sendTxn(4'hA, 4'h5, 4'h6, 4'h3, 0);
        collectOutput(0);
`endif

        $display("[TB] random traffic until txn_cnt wraps");
        wrapped = 1'b0;
        for (int i = 0; i < 300 && !wrapped; i++) begin
            rOp = {2'b00, 2'($urandom_range(0, 3))};
            rA  = 4'($urandom_range(0, 15));
            rB  = 4'($urandom_range(0, 15));
            sendTxn(rOp, rA, rB, aluRef(rOp[1:0], rA, rB), 0);
            collectOutput(0);
            if (expCnt == 8'd0) wrapped = 1'b1;
        end
        checkOutput("wrapSeen", wrapped, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
